// File: rtl/uart_tx_gen.sv
// uart_tx_gen: UART transmitter with a parallel word interface.
//
// Sends one frame per accepted word: start bit (0), DATA_W data bits LSB first,
// an optional parity bit, then STOP_BITS stop bits (1). The line idles high.
// Each bit lasts CLK_PER_BIT clock cycles.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity_odd port and
// a parity bit after the data (even parity when parity_odd=0, odd when 1).
//
// Parameters:
//   DATA_W       data bits per frame (5..9)
//   CLK_PER_BIT  clk cycles per serial bit (>= 2)
//   STOP_BITS    number of stop bits (1 or 2)
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   tx_data      word to send, sampled only on acceptance
//   tx_valid     send request; accepted when tx_ready is also high
//   tx_ready     high while idle (a word can be accepted)
//   parity_odd   parity select, latched on acceptance (UART_TX_PARITY_EN only)
//   tx           registered serial output, idle high
//   busy         high while a frame is on the line (inverse of tx_ready)

module uart_tx_gen #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_PER_BIT = 434,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              tx,
    output logic              busy
);

    localparam int unsigned CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    // Counts data bits in StData and stop bits in StStop.
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                tx_q, tx_d;
    logic                bit_end;
    logic [IDX_W-1:0]    next_idx;

`ifdef UART_TX_PARITY_EN
    logic                parity_odd_q, parity_odd_d;
    logic                parity_bit;

    assign parity_bit = (^data_q) ^ parity_odd_q;
`endif

    assign bit_end  = (baud_q == BAUD_LAST);
    assign next_idx = bit_idx_q + IDX_W'(1);

    // tx_d is the value of the line for the state being entered, so the
    // registered tx changes exactly on the bit boundary.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_odd_d = parity_odd_q;
`endif

        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                baud_d    = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                if (tx_valid) begin
                    state_d = StStart;
                    data_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_odd_d = parity_odd;
`endif
                    tx_d    = 1'b0;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    tx_d      = data_q[0];
                end
            end

            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_bit;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = data_q[next_idx];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d   = StStop;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
`endif

            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = StIdle;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = next_idx;
                    end
                end
            end

            default: begin
                state_d   = StIdle;
                baud_d    = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_odd_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_odd_q <= parity_odd_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == StIdle);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_gen.sv
module tb_uart_tx_gen;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME1 = (1 + DW + P + 1) * CPB;
    localparam int FRAME2 = (1 + DW + P + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_valid, tx_valid2;
    logic       parity_odd, parity_odd2;
    logic       tx_ready, tx, busy;
    logic       tx_ready2, tx2, busy2;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    frame_t exp2_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    initial forever #5 clk = ~clk;

    uart_tx_gen #(.DATA_W(8), .CLK_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .busy       (busy)
    );

    uart_tx_gen #(.DATA_W(8), .CLK_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd2),
`endif
        .tx         (tx2),
        .busy       (busy2)
    );

    function automatic frame_t make_frame(input logic [7:0] d, input logic podd, input int stops);
        frame_t f;
        int idx;
        f.bits = '0;
        f.bits[0] = 1'b0;
        idx = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[idx] = d[i];
            idx++;
        end
`ifdef UART_TX_PARITY_EN
        f.bits[idx] = (^d) ^ podd;
        idx++;
`endif
        for (int i = 0; i < stops; i++) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.len = idx;
        return f;
    endfunction

    // Per-cycle line image: every frame bit repeated CPB times.
    function automatic logic [127:0] exp_samp(input frame_t f);
        logic [127:0] s;
        s = '0;
        for (int k = 0; k < f.len * CPB; k++) s[k] = f.bits[k / CPB];
        return s;
    endfunction

    // Bit value taken from the middle of each bit period.
    function automatic logic [15:0] mid_bits(input logic [127:0] s, input int n);
        logic [15:0] b;
        b = '0;
        for (int k = 0; k < n; k++) b[k] = s[k * CPB + CPB / 2];
        return b;
    endfunction

    // Records tx on every negedge while busy; gap = idle samples before the frame.
    task automatic capture(input int sel, output logic [127:0] samp, output int nbusy,
                           output int gap, output logic idle_tx, output bit tout);
        samp = '0;
        nbusy = 0;
        gap = 0;
        tout = 1'b0;
        idle_tx = 1'b0;
        @(negedge clk);
        while (((sel == 0) ? busy : busy2) !== 1'b1 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        if (gap >= 200) begin
            tout = 1'b1;
            return;
        end
        while (((sel == 0) ? busy : busy2) === 1'b1 && nbusy < 128) begin
            samp[nbusy] = (sel == 0) ? tx : tx2;
            nbusy++;
            @(negedge clk);
        end
        if (nbusy >= 128) tout = 1'b1;
        idle_tx = (sel == 0) ? tx : tx2;
    endtask

    task automatic send(input logic [7:0] d, input logic podd);
        @(posedge clk);
        #1;
        tx_data    = d;
        parity_odd = podd;
        tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        parity_odd = 1'b0;
        tx_valid2 = 1'b1;
        tx_data2 = 8'hFF;
        parity_odd2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", tx_ready);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0)
            $display("FAIL reset_dut2: got tx=%b busy=%b expected tx=1 busy=0", tx2, busy2);
        else n_pass++;
        rst = 1'b0;
        tx_valid = 1'b0;
        tx_valid2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx !== 1'b1)
            $display("FAIL reset_idle_after: got tx=%b busy=%b expected tx=1 busy=0", tx, busy);
        else n_pass++;
    endtask

    task automatic test_basic;
        frame_t e;
        logic [127:0] s;
        int nb, gap;
        logic it;
        bit to;
`ifdef UART_TX_PARITY_EN
        logic [15:0] lit = 16'b00000_10101001010;
`else
        logic [15:0] lit = 16'b000000_1101001010;
`endif
        exp_q.push_back(make_frame(8'hA5, 1'b0, 1));
        send(8'hA5, 1'b0);
        capture(0, s, nb, gap, it, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to) $display("FAIL basic_timeout: got timeout expected frame"); else n_pass++;
        n_checks++;
        if (gap !== 0) $display("FAIL basic_latency: got %0d idle cycles expected 0", gap);
        else n_pass++;
        n_checks++;
        if (s !== exp_samp(e)) $display("FAIL basic_line: got %h expected %h", s, exp_samp(e));
        else n_pass++;
        n_checks++;
        if (mid_bits(s, e.len) !== lit)
            $display("FAIL basic_bits: got %b expected %b", mid_bits(s, e.len), lit);
        else n_pass++;
        n_checks++;
        if (nb !== FRAME1) $display("FAIL basic_busy_len: got %0d expected %0d", nb, FRAME1);
        else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b1 || it !== 1'b1)
            $display("FAIL basic_ready_after: got ready=%b tx=%b expected 1 1", tx_ready, it);
        else n_pass++;
    endtask

    task automatic test_parity;
        frame_t e;
        logic [127:0] s;
        int nb, gap;
        logic it;
        bit to;
        for (int i = 0; i < 2; i++) begin
            logic podd;
            podd = (i == 0) ? 1'b1 : 1'b0;
            exp_q.push_back(make_frame(8'h01, podd, 1));
            send(8'h01, podd);
            capture(0, s, nb, gap, it, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || s !== exp_samp(e))
                $display("FAIL parity_frame%0d: got %h expected %h", i, s, exp_samp(e));
            else n_pass++;
`ifdef UART_TX_PARITY_EN
            n_checks++;
            if (s[9 * CPB + 2] !== ~podd)
                $display("FAIL parity_bit%0d: got %b expected %b", i, s[9 * CPB + 2], ~podd);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_back_to_back;
        frame_t e;
        logic [127:0] s1, s2;
        int nb1, nb2, gap1, gap2;
        logic it1, it2;
        bit to1, to2;
        @(posedge clk);
        #1;
        tx_data = 8'h55;
        parity_odd = 1'b0;
        tx_valid = 1'b1;
        exp_q.push_back(make_frame(8'h55, 1'b0, 1));
        @(posedge clk);
        #1;
        // Changing inputs mid-frame must not alter the frame in flight.
        tx_data = 8'h0F;
        parity_odd = 1'b1;
        exp_q.push_back(make_frame(8'h0F, 1'b1, 1));
        capture(0, s1, nb1, gap1, it1, to1);
        fork
            capture(0, s2, nb2, gap2, it2, to2);
            begin
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        e = exp_q.pop_front();
        n_checks++;
        if (to1 || s1 !== exp_samp(e))
            $display("FAIL b2b_frame1: got %h expected %h", s1, exp_samp(e));
        else n_pass++;
        n_checks++;
        if (it1 !== 1'b1) $display("FAIL b2b_idle_tx: got %b expected 1", it1); else n_pass++;
        n_checks++;
        if (gap2 !== 0) $display("FAIL b2b_gap: got %0d extra idle expected 0", gap2);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (to2 || s2 !== exp_samp(e))
            $display("FAIL b2b_frame2: got %h expected %h", s2, exp_samp(e));
        else n_pass++;
        n_checks++;
        if (nb2 !== FRAME1) $display("FAIL b2b_len2: got %0d expected %0d", nb2, FRAME1);
        else n_pass++;
    endtask

    task automatic test_ignore_busy;
        frame_t e;
        logic [127:0] s;
        int nb, gap, extra;
        logic it;
        bit to;
        exp_q.push_back(make_frame(8'h96, 1'b0, 1));
        send(8'h96, 1'b0);
        fork
            capture(0, s, nb, gap, it, to);
            begin
                repeat (10) @(posedge clk);
                #1;
                tx_data = 8'hFF;
                parity_odd = 1'b1;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        e = exp_q.pop_front();
        n_checks++;
        if (to || s !== exp_samp(e))
            $display("FAIL ignore_frame: got %h expected %h", s, exp_samp(e));
        else n_pass++;
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL ignore_no_extra: got %0d busy cycles expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        frame_t e;
        logic [127:0] s;
        int nb, gap;
        logic it;
        bit to;
        send(8'hC3, 1'b0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b0 || busy !== 1'b1)
            $display("FAIL rstmid_bit3: got tx=%b busy=%b expected tx=0 busy=1", tx, busy);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx); else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rstmid_ready: got ready=%b busy=%b expected 1 0", tx_ready, busy);
        else n_pass++;
        exp_q.push_back(make_frame(8'h3C, 1'b0, 1));
        send(8'h3C, 1'b0);
        capture(0, s, nb, gap, it, to);
        e = exp_q.pop_front();
        n_checks++;
        if (to || s !== exp_samp(e))
            $display("FAIL rstmid_new_frame: got %h expected %h", s, exp_samp(e));
        else n_pass++;
        n_checks++;
        if (nb !== FRAME1) $display("FAIL rstmid_len: got %0d expected %0d", nb, FRAME1);
        else n_pass++;
    endtask

    task automatic test_stop2;
        frame_t e;
        logic [127:0] s;
        int nb, gap;
        logic it;
        bit to;
        exp2_q.push_back(make_frame(8'h80, 1'b0, 2));
        @(posedge clk);
        #1;
        tx_data2 = 8'h80;
        parity_odd2 = 1'b0;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        capture(1, s, nb, gap, it, to);
        e = exp2_q.pop_front();
        n_checks++;
        if (to || s !== exp_samp(e))
            $display("FAIL stop2_frame: got %h expected %h", s, exp_samp(e));
        else n_pass++;
        n_checks++;
        if (nb !== FRAME2) $display("FAIL stop2_len: got %0d expected %0d", nb, FRAME2);
        else n_pass++;
`ifndef UART_TX_PARITY_EN
        begin
            logic [15:0] lit = 16'b00000_11100000000;
            n_checks++;
            if (mid_bits(s, 11) !== lit)
                $display("FAIL stop2_bits: got %b expected %b", mid_bits(s, 11), lit);
            else n_pass++;
        end
`endif
        n_checks++;
        if (tx_ready2 !== 1'b1) $display("FAIL stop2_ready: got %b expected 1", tx_ready2);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_stop2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
